// File: rtl/lab_config_pkg.sv
// Shared types and default sizing for the LAB configuration loaders.
package lab_config_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT,
    DONE,
    ERROR
  } lab_loader_state_t;

  localparam int LAB_PIA_INPUT_SIGNAL_COUNT = 36;
  localparam int PIA_BUS_SIGNAL_COUNT       = 200;
  localparam int PIA_SELECT_WIDTH           = 8;

endpackage

// File: rtl/lab_shift_counter.sv
// Bit/index counter pair for serial configuration loaders; bits wrap into the index.
// Also reusable by the macrocell configuration loader.
module lab_shift_counter #(
  parameter int BIT_COUNT   = 8,
  parameter int INDEX_COUNT = 36,
  parameter int BIT_W       = $clog2(BIT_COUNT),
  parameter int INDEX_W     = $clog2(INDEX_COUNT)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear_req,
  input  logic               step_bit,
  input  logic               step_index,
  output logic [BIT_W-1:0]   bit_count,
  output logic [INDEX_W-1:0] index_count,
  output logic               last_bit,
  output logic               last_index,
  output logic               clear
);

  assign last_bit   = (bit_count == BIT_W'(BIT_COUNT - 1));
  assign last_index = (index_count == INDEX_W'(INDEX_COUNT - 1));
  // Single source of the restart event so the owner can reset its own state with it.
  assign clear      = clear_req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_count   <= '0;
      index_count <= '0;
    end else if (clear_req) begin
      bit_count   <= '0;
      index_count <= '0;
    end else if (step_bit) begin
      if (last_bit) begin
        bit_count   <= '0;
        index_count <= last_index ? '0 : index_count + 1'b1;
      end else begin
        bit_count <= bit_count + 1'b1;
      end
    end else if (step_index) begin
      index_count <= last_index ? '0 : index_count + 1'b1;
    end
  end

endmodule

// File: rtl/lab_pia_select_loader.sv
// Serial loader for the PIA-to-LAB selection indices: shift, range-check, then commit atomically.
// Optional per-index even parity bit enabled by defining LAB_PIA_SELECT_PARITY_EN.
module lab_pia_select_loader
  import lab_config_pkg::*;
#(
  parameter int pia_input_signal_count = LAB_PIA_INPUT_SIGNAL_COUNT,
  parameter int pia_bus_signal_count   = PIA_BUS_SIGNAL_COUNT,
  parameter int select_width           = PIA_SELECT_WIDTH
) (
  input  logic                                           clock,
  input  logic                                           reset_n,
  input  logic                                           start,
  input  logic                                           bit_in,
  input  logic                                           bit_valid,
  output logic                                           bit_ready,
  output logic [pia_input_signal_count*select_width-1:0] selection_indices,
  output logic                                           config_valid,
  output logic                                           busy,
  output logic                                           error
);

`ifdef LAB_PIA_SELECT_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  localparam int BITS_PER_INDEX = select_width + PARITY_BITS;
  localparam int BIT_W          = $clog2(BITS_PER_INDEX);
  localparam int INDEX_W        = $clog2(pia_input_signal_count);
  localparam int SEL_W          = $clog2(select_width);
  localparam logic [select_width:0] BUS_LIMIT = (select_width + 1)'(pia_bus_signal_count);

  lab_loader_state_t state, state_next;

  logic [select_width-1:0] shadow [pia_input_signal_count];
  logic [BIT_W-1:0]        bit_count;
  logic [INDEX_W-1:0]      index_count;
  logic last_bit, last_index, restart;
  logic clear_req, step_bit, step_index, set_error, commit;
  logic transfer, write_data, parity_bad, out_of_range;

  lab_shift_counter #(
    .BIT_COUNT  (BITS_PER_INDEX),
    .INDEX_COUNT(pia_input_signal_count),
    .BIT_W      (BIT_W),
    .INDEX_W    (INDEX_W)
  ) u_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_req  (clear_req),
    .step_bit   (step_bit),
    .step_index (step_index),
    .bit_count  (bit_count),
    .index_count(index_count),
    .last_bit   (last_bit),
    .last_index (last_index),
    .clear      (restart)
  );

  assign bit_ready    = (state == LOAD);
  assign busy         = (state == LOAD) || (state == CHECK) || (state == COMMIT);
  assign transfer     = bit_valid && bit_ready;
  assign out_of_range = ({1'b0, shadow[index_count]} >= BUS_LIMIT);

  // The parity slot is the last bit of each index; all data bits are already in the shadow.
`ifdef LAB_PIA_SELECT_PARITY_EN
  assign write_data = !last_bit;
  assign parity_bad = last_bit && ((^shadow[index_count]) != bit_in);
`else
  assign write_data = 1'b1;
  assign parity_bad = 1'b0;
`endif

  always_comb begin
    state_next = state;
    clear_req  = 1'b0;
    step_bit   = 1'b0;
    step_index = 1'b0;
    set_error  = 1'b0;
    commit     = 1'b0;
    unique case (state)
      LOAD: begin
        if (start) begin
          clear_req = 1'b1;
        end else if (transfer) begin
          step_bit = 1'b1;
          if (parity_bad) begin
            state_next = ERROR;
            set_error  = 1'b1;
          end else if (last_bit && last_index) begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        if (start) begin
          clear_req  = 1'b1;
          state_next = LOAD;
        end else if (out_of_range) begin
          state_next = ERROR;
          set_error  = 1'b1;
        end else begin
          step_index = 1'b1;
          if (last_index) state_next = COMMIT;
        end
      end
      COMMIT: begin
        commit     = 1'b1;
        state_next = DONE;
      end
      default: begin
        if (start) begin
          clear_req  = 1'b1;
          state_next = LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      error             <= 1'b0;
      config_valid      <= 1'b0;
      selection_indices <= '0;
    end else begin
      state <= state_next;
      if (restart) error <= 1'b0;
      else if (set_error) error <= 1'b1;
      if (commit) begin
        config_valid <= 1'b1;
        for (int i = 0; i < pia_input_signal_count; i++)
          selection_indices[i*select_width +: select_width] <= shadow[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < pia_input_signal_count; i++) shadow[i] <= '0;
    end else if (transfer && write_data) begin
      shadow[index_count][bit_count[SEL_W-1:0]] <= bit_in;
    end
  end

endmodule

// File: doc/lab_pia_select_loader.md
Name: lab_pia_select_loader

Overview:
Configuration sequencer for one logic array block. It receives a serial bitstream of PIA selection indices, one index per LAB input, over a valid/ready handshake. It range-checks every index, then atomically commits the full set to the selection outputs that drive the PIA-to-LAB multiplexers, which produce the LAB's 36 selected_pia_signals. A failed load leaves the previously committed configuration active.

Parameters:
pia_input_signal_count, 36, number of LAB inputs selected from the PIA
pia_bus_signal_count, 200, number of signals on the global PIA bus; legal index range is 0..pia_bus_signal_count-1
select_width, 8, bits per selection index; must satisfy 2**select_width >= pia_bus_signal_count

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a load
bit_in  input  1  serial configuration bit
bit_valid  input  1  bit_in is valid this cycle
bit_ready  output  1  loader accepts a bit this cycle; a transfer occurs when bit_valid && bit_ready
selection_indices  output  pia_input_signal_count*select_width  committed indices; index i occupies bits [i*select_width +: select_width]
config_valid  output  1  a committed configuration exists
busy  output  1  state is not IDLE, DONE or ERROR
error  output  1  last load failed; held until the next start

Behaviour:
- Reset (asynchronous, sets all state immediately):
  - state=IDLE; shadow register, selection_indices, bit counter and index counter=0
  - config_valid=0, error=0, bit_ready=0, busy=0
- States: IDLE, LOAD, CHECK, COMMIT, DONE, ERROR.
- IDLE, DONE, ERROR: start -> LOAD. Entering LOAD clears both counters and error. The shadow register is not cleared.
- LOAD:
  - bit_ready=1.
  - Each transfer writes bit_in into shadow[index][bit]. Bits arrive LSB first; index 0 arrives first.
  - bit wraps at select_width-1 and increments index.
  - The transfer of the last bit (index=pia_input_signal_count-1, bit=select_width-1) moves to CHECK on the next cycle.
  - bit_valid low stalls the load with no timeout.
- CHECK:
  - bit_ready=0. Checks one index per cycle, 0 upward.
  - An index >= pia_bus_signal_count moves to ERROR immediately; later indices are not checked.
  - All indices pass -> COMMIT. CHECK takes exactly pia_input_signal_count cycles on success.
- COMMIT: one cycle. Copies shadow to selection_indices in a single edge, sets config_valid=1, then -> DONE.
- ERROR: error=1. selection_indices and config_valid keep their prior values.
- start during LOAD or CHECK aborts the current load and restarts LOAD with counters cleared. Bits already shifted are overwritten by the new load. Committed outputs are untouched.
- start in the same cycle as the final LOAD transfer: start wins and the load restarts.
- start during COMMIT is ignored.
- Latency: the last bit accepted at edge N gives selection_indices and config_valid updated at edge N+pia_input_signal_count+1.
- selection_indices changes only in COMMIT or reset; it never shows a partial configuration.

Optional Feature:
Macro LAB_PIA_SELECT_PARITY_EN.
- Defined: each index is followed by one even-parity bit, making select_width+1 transfers per index. The parity bit is checked on arrival. On mismatch the block enters ERROR at the next edge and ignores the remaining bits; bit_ready drops.
- Undefined: no parity bits; the stream is exactly pia_input_signal_count*select_width bits.

Decomposition:
- Shared package lab_config_pkg holds:
  - state enum lab_loader_state_t
  - default constants LAB_PIA_INPUT_SIGNAL_COUNT=36, PIA_BUS_SIGNAL_COUNT=200, PIA_SELECT_WIDTH=8
- One natural sub-module: lab_shift_counter, the bit/index counter pair. It provides last_bit, last_index and clear outputs and is reusable by the future macrocell configuration loader.
- Range check and shadow storage stay in the top module.

Test Plan:
- Reset, then load indices i*5 (0..175) with bit_valid constantly 1 -> bit_ready high 288 cycles; selection_indices[i]=i*5; config_valid rises 37 cycles after the last bit; error=0.
- Commit pattern A, then load pattern B with index 20=210 -> error=1 after CHECK reaches index 20 (21 cycles); selection_indices remains A; config_valid stays 1.
- Random bit_valid gaps (50% duty) during a load of all indices=199 -> stalls honoured; commit of 199 everywhere; no error.
- start pulse after 100 bits, then a full load of all-zero indices -> counters restart at 0; final selection_indices all zero; earlier bits have no effect.
- reset_n asserted mid-CHECK -> all outputs 0 immediately and asynchronously; state IDLE; config_valid=0.
- With LAB_PIA_SELECT_PARITY_EN, a corrupted parity bit on index 3 -> ERROR one edge later; bit_ready=0; prior configuration retained.
